// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port req/gnt arbiter sharing one RAM, registered RAM controls, 2-cycle read return.
// Round robin by default; define ARB_FIXED_PRIO_EN for fixed priority (port 0) with port-1 aging.
`default_nettype none
module ram_arbiter #(
  parameter int WIDTH     = 32,
  parameter int WORD_SIZE = 8,
  parameter int MAX_WAIT  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 p0_req,
  input  logic                 p1_req,
  input  logic                 p0_we,
  input  logic                 p1_we,
  input  logic [WORD_SIZE-1:0] p0_addr,
  input  logic [WORD_SIZE-1:0] p1_addr,
  input  logic [WIDTH-1:0]     p0_wdata,
  input  logic [WIDTH-1:0]     p1_wdata,
  output logic                 p0_gnt,
  output logic                 p1_gnt,
  output logic                 p0_rvalid,
  output logic                 p1_rvalid,
  output logic [WIDTH-1:0]     p0_rdata,
  output logic [WIDTH-1:0]     p1_rdata,
  output logic                 ram_wr_en,
  output logic [WORD_SIZE-1:0] ram_wr_addr,
  output logic [WORD_SIZE-1:0] ram_rd_addr,
  output logic [WIDTH-1:0]     ram_data_in,
  input  logic [WIDTH-1:0]     ram_data_out
);

  logic                 hs;
  logic                 sel;
  logic                 req_we;
  logic [WORD_SIZE-1:0] req_addr;
  logic [WIDTH-1:0]     req_wdata;
  logic                 rd_s1_valid;
  logic                 rd_s1_port;

`ifdef ARB_FIXED_PRIO_EN
  localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT);
  logic [WAIT_W-1:0] wait1;
`else
  logic        last;
  logic [31:0] unused_max_wait;
  assign unused_max_wait = MAX_WAIT;
`endif

  // Grants are combinational so a lone request is accepted in the same cycle.
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (!rst) begin
      if (p0_req && p1_req) begin
`ifdef ARB_FIXED_PRIO_EN
        if (wait1 >= WAIT_SAT) p1_gnt = 1'b1;
        else                   p0_gnt = 1'b1;
`else
        if (last) p0_gnt = 1'b1;
        else      p1_gnt = 1'b1;
`endif
      end else begin
        p0_gnt = p0_req;
        p1_gnt = p1_req;
      end
    end
  end

  assign hs        = p0_gnt | p1_gnt;
  assign sel       = p1_gnt;
  assign req_we    = sel ? p1_we    : p0_we;
  assign req_addr  = sel ? p1_addr  : p0_addr;
  assign req_wdata = sel ? p1_wdata : p0_wdata;

`ifdef ARB_FIXED_PRIO_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               wait1 <= '0;
    else if (p1_gnt)                       wait1 <= '0;
    else if (p1_req && (wait1 < WAIT_SAT)) wait1 <= wait1 + 1'b1;
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     last <= 1'b0;
    else if (hs) last <= sel;
  end
`endif

  // Stage 1 tracks the cycle the RAM sees the read address; stage 2 is the rvalid cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_wr_en   <= 1'b0;
      ram_wr_addr <= '0;
      ram_rd_addr <= '0;
      ram_data_in <= '0;
      rd_s1_valid <= 1'b0;
      rd_s1_port  <= 1'b0;
      p0_rvalid   <= 1'b0;
      p1_rvalid   <= 1'b0;
    end else begin
      ram_wr_en   <= hs & req_we;
      rd_s1_valid <= hs & ~req_we;
      if (hs) begin
        if (req_we) begin
          ram_wr_addr <= req_addr;
          ram_data_in <= req_wdata;
        end else begin
          ram_rd_addr <= req_addr;
          rd_s1_port  <= sel;
        end
      end
      p0_rvalid <= rd_s1_valid & ~rd_s1_port;
      p1_rvalid <= rd_s1_valid &  rd_s1_port;
    end
  end

  assign p0_rdata = p0_rvalid ? ram_data_out : '0;
  assign p1_rdata = p1_rvalid ? ram_data_out : '0;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed stimulus with a per-cycle reference model and literal spot checks.
`default_nettype none
module tb_ram_arbiter;
  localparam int WIDTH     = 32;
  localparam int WORD_SIZE = 8;
  localparam int MAX_WAIT  = 4;
  localparam int DEPTH     = 1 << WORD_SIZE;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 p0_req = 1'b0, p1_req = 1'b0, p0_we = 1'b0, p1_we = 1'b0;
  logic [WORD_SIZE-1:0] p0_addr = '0, p1_addr = '0;
  logic [WIDTH-1:0]     p0_wdata = '0, p1_wdata = '0;
  logic                 p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [WIDTH-1:0]     p0_rdata, p1_rdata;
  logic                 ram_wr_en;
  logic [WORD_SIZE-1:0] ram_wr_addr, ram_rd_addr;
  logic [WIDTH-1:0]     ram_data_in;
  logic [WIDTH-1:0]     ram_data_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.WIDTH(WIDTH), .WORD_SIZE(WORD_SIZE), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p1_req(p1_req), .p0_we(p0_we), .p1_we(p1_we),
    .p0_addr(p0_addr), .p1_addr(p1_addr), .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_rd_addr(ram_rd_addr),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  // Synchronous RAM: write and registered read on the same edge.
  logic             mem_load = 1'b1;
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= WIDTH'(i * 11);
    end else if (ram_wr_en) begin
      mem[ram_wr_addr] <= ram_data_in;
    end
    ram_data_out <= mem[ram_rd_addr];
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a word-level view of the RAM plus per-port return slots.
  logic [WIDTH-1:0]     ref_mem [DEPTH];
  logic                 m_last;
  int                   m_wait;
  logic                 cur_v [2], nxt_v [2];
  logic [WIDTH-1:0]     cur_d [2], nxt_d [2];
  logic                 e_wr_en;
  logic [WORD_SIZE-1:0] e_wr_addr, e_rd_addr;
  logic [WIDTH-1:0]     e_data_in;

  task automatic model_reset();
    m_last = 1'b0; m_wait = 0;
    e_wr_en = 1'b0; e_wr_addr = '0; e_rd_addr = '0; e_data_in = '0;
    for (int p = 0; p < 2; p++) begin
      cur_v[p] = 1'b0; nxt_v[p] = 1'b0; cur_d[p] = '0; nxt_d[p] = '0;
    end
  endtask

  initial begin : model
    logic                 eg0, eg1, w;
    int                   s;
    logic [WORD_SIZE-1:0] a;
    logic [WIDTH-1:0]     d;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = WIDTH'(i * 11);
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_p0_gnt", p0_gnt, 0);      check("rst_p1_gnt", p1_gnt, 0);
        check("rst_p0_rvalid", p0_rvalid, 0); check("rst_p1_rvalid", p1_rvalid, 0);
        check("rst_p0_rdata", p0_rdata, 0);   check("rst_p1_rdata", p1_rdata, 0);
        check("rst_wr_en", ram_wr_en, 0);     check("rst_wr_addr", ram_wr_addr, 0);
        check("rst_rd_addr", ram_rd_addr, 0); check("rst_data_in", ram_data_in, 0);
        model_reset();
      end else begin
        eg0 = p0_req; eg1 = p1_req;
        if (p0_req && p1_req) begin
`ifdef ARB_FIXED_PRIO_EN
          eg1 = (m_wait >= MAX_WAIT);
`else
          eg1 = (m_last == 1'b0);
`endif
          eg0 = !eg1;
        end
        check("p0_gnt", p0_gnt, eg0);              check("p1_gnt", p1_gnt, eg1);
        check("p0_rvalid", p0_rvalid, cur_v[0]);    check("p1_rvalid", p1_rvalid, cur_v[1]);
        check("p0_rdata", p0_rdata, cur_v[0] ? cur_d[0] : '0);
        check("p1_rdata", p1_rdata, cur_v[1] ? cur_d[1] : '0);
        check("ram_wr_en", ram_wr_en, e_wr_en);     check("ram_wr_addr", ram_wr_addr, e_wr_addr);
        check("ram_rd_addr", ram_rd_addr, e_rd_addr); check("ram_data_in", ram_data_in, e_data_in);
        for (int p = 0; p < 2; p++) begin
          cur_v[p] = nxt_v[p]; cur_d[p] = nxt_d[p]; nxt_v[p] = 1'b0; nxt_d[p] = '0;
        end
        e_wr_en = 1'b0;
        if (eg0 || eg1) begin
          s = eg1 ? 1 : 0;
          w = eg1 ? p1_we : p0_we;
          a = eg1 ? p1_addr : p0_addr;
          d = eg1 ? p1_wdata : p0_wdata;
          e_wr_en = w;
          if (w) begin
            e_wr_addr = a; e_data_in = d; ref_mem[a] = d;
          end else begin
            e_rd_addr = a; nxt_v[s] = 1'b1; nxt_d[s] = ref_mem[a];
          end
          m_last = eg1;
        end
        if (eg1) m_wait = 0;
        else if (p1_req && m_wait < MAX_WAIT) m_wait++;
      end
    end
  end

  task automatic drive(input logic r0, input logic w0, input logic [WORD_SIZE-1:0] a0,
                       input logic [WIDTH-1:0] d0, input logic r1, input logic w1,
                       input logic [WORD_SIZE-1:0] a1, input logic [WIDTH-1:0] d1);
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
  endtask

  task automatic idle();
    drive(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    next();
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int a0, a1, k, guard;
    idle();
    next();
    mem_load = 1'b0;
    next(); next();
    rst = 1'b0;

    // p0 write then read of the same word
    drive(1, 1, 8'h05, 32'd11, 0, 0, '0, '0);
    @(negedge clk); check("t1_wr_gnt", p0_gnt, 1); check("t1_wr_p1gnt", p1_gnt, 0); next();
    drive(1, 0, 8'h05, '0, 0, 0, '0, '0);
    @(negedge clk); check("t1_rd_gnt", p0_gnt, 1); next();
    idle();
    @(negedge clk); check("t1_early_rvalid", p0_rvalid, 0); next();
    @(negedge clk);
    check("t1_rvalid", p0_rvalid, 1); check("t1_rdata", p0_rdata, 11);
    check("t1_p1_rvalid", p1_rvalid, 0); check("t1_p1_rdata", p1_rdata, 0);
    next();

    // both ports reading continuously
    pulse_reset();
    a0 = 0; a1 = 8; k = 0; guard = 0;
    while ((a0 < 8 || a1 < 16) && guard < 40) begin
      drive(a0 < 8, 0, WORD_SIZE'(a0), '0, a1 < 16, 0, WORD_SIZE'(a1), '0);
      @(negedge clk);
`ifndef ARB_FIXED_PRIO_EN
      if (a0 < 8 && a1 < 16) begin
        check("t2_rr_p1_gnt", p1_gnt, (k % 2) == 0);
        check("t2_rr_p0_gnt", p0_gnt, (k % 2) == 1);
        k++;
      end
`endif
      if (p0_gnt) a0++;
      if (p1_gnt) a1++;
      next();
      guard++;
    end
    check("t2_no_timeout", guard < 40, 1);
    idle();
    next(); next(); next();

    // p1 write followed by p0 read of the same address
    drive(0, 0, '0, '0, 1, 1, 8'h10, 32'd55);
    @(negedge clk); check("t3_p1_wr_gnt", p1_gnt, 1); next();
    drive(1, 0, 8'h10, '0, 0, 0, '0, '0);
    next();
    idle();
    next();
    @(negedge clk); check("t3_rvalid", p0_rvalid, 1); check("t3_rdata", p0_rdata, 55); next();

    // reset while a read is in flight
    drive(1, 0, 8'h03, '0, 0, 0, '0, '0);
    @(negedge clk); check("t4_gnt", p0_gnt, 1); next();
    rst = 1'b1;
    drive(1, 0, 8'h04, '0, 1, 0, 8'h09, '0);
    @(negedge clk);
    check("t4_rst_p0_gnt", p0_gnt, 0); check("t4_rst_p1_gnt", p1_gnt, 0);
    check("t4_rst_wr_en", ram_wr_en, 0); check("t4_rst_rd_addr", ram_rd_addr, 0);
    next();
    rst = 1'b0;
    @(negedge clk);
    check("t4_no_rvalid", p0_rvalid, 0);
`ifdef ARB_FIXED_PRIO_EN
    check("t4_first_gnt_p0", p0_gnt, 1);
`else
    check("t4_first_gnt_p1", p1_gnt, 1);
`endif
    next();
    idle();
    next(); next(); next();

`ifdef ARB_FIXED_PRIO_EN
    // fixed priority with aging: p0 x4 then p1, repeating
    pulse_reset();
    for (int c = 0; c < 10; c++) begin
      drive(1, 0, 8'h01, '0, 1, 0, 8'h02, '0);
      @(negedge clk);
      check("t5_p1_gnt", p1_gnt, (c % 5) == 4);
      check("t5_p0_gnt", p0_gnt, (c % 5) != 4);
      next();
    end
    idle();
    next(); next(); next();
`endif

    // top address write, read back by p1, address 0 untouched
    drive(1, 1, 8'hFF, 32'd88, 0, 0, '0, '0);
    next();
    drive(0, 0, '0, '0, 1, 0, 8'hFF, '0);
    @(negedge clk); check("t6_wr_addr", ram_wr_addr, 8'hFF); check("t6_data_in", ram_data_in, 88); next();
    drive(0, 0, '0, '0, 1, 0, 8'h00, '0);
    next();
    idle();
    @(negedge clk); check("t6_rvalid", p1_rvalid, 1); check("t6_rdata", p1_rdata, 88); next();
    @(negedge clk); check("t6_rvalid0", p1_rvalid, 1); check("t6_rdata0", p1_rdata, 0); next();
    next(); next();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single CPU RAM between the instruction-fetch requester (port 0) and the load/store requester (port 1). It accepts one request per cycle using a req/gnt handshake and drives the RAM write and read controls from registers. It returns read data to the requesting port with a fixed latency. It sits between the fetch/LSU logic and the `ram` instance in the CPU top level.

## Interface
Parameters:
- `WIDTH`, 32: data width, matches the RAM data width.
- `WORD_SIZE`, 8: address width in bits, matches the RAM address width (2**WORD_SIZE words).
- `MAX_WAIT`, 4: aging threshold in cycles, used only with `ARB_FIXED_PRIO_EN`.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `p0_req`, `p1_req`  in  1  request valid.
- `p0_we`, `p1_we`  in  1  1 = write, 0 = read.
- `p0_addr`, `p1_addr`  in  WORD_SIZE  word address.
- `p0_wdata`, `p1_wdata`  in  WIDTH  write data.
- `p0_gnt`, `p1_gnt`  out  1  request accepted this cycle; combinational.
- `p0_rvalid`, `p1_rvalid`  out  1  read data valid, registered.
- `p0_rdata`, `p1_rdata`  out  WIDTH  read data; 0 when the matching rvalid is low.
- `ram_wr_en`  out  1  RAM write enable, registered.
- `ram_wr_addr`, `ram_rd_addr`  out  WORD_SIZE  RAM addresses, registered.
- `ram_data_in`  out  WIDTH  RAM write data, registered.
- `ram_data_out`  in  WIDTH  RAM read data; valid one edge after `ram_rd_addr` is presented.

## Operation
- A handshake completes when `pX_req` and `pX_gnt` are both high at a rising edge.
- Requester rules:
  - The requester holds `we`, `addr` and `wdata` stable while `req` is high and `gnt` is low.
  - The requester may drop or change them after the handshake.
- At most one `gnt` is high per cycle. A lone request is granted in the same cycle.
- Default mode is round robin:
  - `last` (1 bit, reset 0) records the most recently granted port.
  - When both ports request, the port that is not `last` wins.
  - `last` updates only on a grant.
- On a handshake:
  - `ram_wr_en` is set to `we`.
  - For a write, `ram_wr_addr` and `ram_data_in` load the request's address and data.
  - For a read, `ram_rd_addr` loads the address and a 2-stage read pipeline (valid bit + port id) loads 1.
- With no handshake, `ram_wr_en` is 0 and the address/data registers hold their values.
- A write does not assert rvalid.
- Reset (asynchronous, at any time):
  - All `gnt` outputs are forced 0 while `rst` is high.
  - All `rvalid` and `rdata` outputs and all `ram_*` outputs go to 0.
  - `last` goes to 0 and the wait counter goes to 0.
  - In-flight reads are discarded and never return rvalid.

## Timing
- Request handshaken in cycle N:
  - RAM controls are driven in cycle N+1.
  - The RAM write commits, or read data is captured, at the end of cycle N+1.
  - `pX_rvalid` is high for exactly one cycle, N+2, with `pX_rdata = ram_data_out`.
- Throughput is one request per cycle; reads issued back to back return back to back.
- Write in cycle N followed by a read of the same address in cycle N+1, from either port: the read returns the new data. No hazard logic is needed.
- Address 2**WORD_SIZE-1 is valid; there is no wrap or increment in this block.

## Configuration
- `ARB_FIXED_PRIO_EN` defined: fixed priority with aging.
  - Port 0 wins ties unless `wait1 >= MAX_WAIT`, in which case port 1 wins.
  - `wait1` increments each cycle `p1_req & ~p1_gnt`, saturates at `MAX_WAIT`, and clears on a port 1 grant.
  - `last` is unused.
- `ARB_FIXED_PRIO_EN` undefined: round robin as described above. `MAX_WAIT` has no effect.

## Test plan
- p0 writes addr 0x05 = 11 in cycle 1, then reads 0x05 in cycle 2 -> `p0_gnt` high in both cycles; `p0_rvalid` high only in cycle 4 with `p0_rdata = 11`; `p1_*` outputs stay 0.
- RAM preloaded with `mem[i] = i*11`; both ports request reads continuously (p0 reads 0–7, p1 reads 8–15) -> grants alternate p1, p0, p1, … (`last` = 0 after reset); each rvalid arrives 2 cycles after its grant with the correct value.
- p1 writes 0x10 = 55 in cycle N, p0 reads 0x10 in cycle N+1 -> `p0_rdata = 55` in cycle N+3.
- p0 read granted in cycle N, `rst` pulsed in cycle N+1 -> no `p0_rvalid`; all outputs 0 during reset; the first grant after reset follows the round-robin rule with `last` = 0.
- `ARB_FIXED_PRIO_EN` defined, `MAX_WAIT = 4`, both ports requesting continuously -> pattern p0, p0, p0, p0, p1, repeating.
- Addr 0xFF write 88 by p0, read by p1 -> `p1_rdata = 88`; addr 0x00 unaffected.
